// File: rtl/ddr2_wr_sched.sv
// ddr2_wr_sched
// Write-side scheduler between the 32->64 packer and the Virtex-5 MIG DDR2
// user interface. Packed words are buffered in a first-word-fall-through
// FIFO. They are sent as bursts of BURST_BEATS beats on app_wdf_*, and each
// burst is followed by one write command on app_af_*. The command address
// auto-increments by ADDR_STEP. A flush pads a trailing partial burst with
// masked zero beats.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   din, din_vd         packed input word and its valid (no backpressure)
//   flush               pulse: drain FIFO, padding the final burst
//   start_addr/start_ld load the address counter (honoured in IDLE only)
//   app_wdf_afull       MIG write-data FIFO almost full
//   app_af_afull        MIG address FIFO almost full
//   app_wdf_*           registered write data, byte mask (1 = masked), strobe
//   app_af_*            registered command address, command (write), strobe
//   busy                FSM not idle or flush pending
//   overflow            sticky: a word arrived while the FIFO was full
//   fifo_level          FIFO occupancy
//   burst_cnt           number of commands issued (wraps)
module ddr2_wr_sched #(
    parameter int              DW          = 64,
    parameter int              AW          = 31,
    parameter int              BURST_BEATS = 2,
    parameter int              FIFO_AW     = 4,
    parameter logic [AW-1:0]   BASE_ADDR   = '0,
    parameter int              ADDR_STEP   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DW-1:0]        din,
    input  logic                 din_vd,
    input  logic                 flush,
    input  logic [AW-1:0]        start_addr,
    input  logic                 start_ld,
    input  logic                 app_wdf_afull,
    input  logic                 app_af_afull,
    output logic [DW-1:0]        app_wdf_data,
    output logic [DW/8-1:0]      app_wdf_mask_data,
    output logic                 app_wdf_wren,
    output logic [AW-1:0]        app_af_addr,
    output logic [2:0]           app_af_cmd,
    output logic                 app_af_wren,
    output logic                 busy,
    output logic                 overflow,
    output logic [FIFO_AW:0]     fifo_level,
    output logic [15:0]          burst_cnt
);

    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam int               BCW       = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [BCW-1:0]   LAST_BEAT = BCW'(BURST_BEATS - 1);
    localparam logic [FIFO_AW:0] BURST_LVL = (FIFO_AW + 1)'(BURST_BEATS);
    localparam logic [FIFO_AW:0] FULL_LVL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [AW-1:0]    STEP      = AW'(ADDR_STEP);

    typedef enum logic [1:0] {S_IDLE, S_WDATA, S_CMD} state_t;

    state_t                r_state;
    logic [BCW-1:0]        r_beat_cnt;
    logic [AW-1:0]         r_addr_cnt;
    logic                  r_flush_pend;

    logic [DW-1:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0]    r_wr_ptr;
    logic [FIFO_AW-1:0]    r_rd_ptr;
    logic [FIFO_AW:0]      r_level;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_go;
    logic                  w_beat;
    logic                  w_pop;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == FULL_LVL);
    assign w_push  = din_vd && !w_full;

    // The first beat is emitted on the IDLE->WDATA decision so that data
    // appears two cycles after the completing input word. Starting is held
    // off while the previous command strobe is still out. This keeps bursts
    // at least BURST_BEATS+2 cycles apart.
    assign w_go   = (r_state == S_IDLE) && !app_wdf_afull && !app_af_afull && !app_af_wren &&
                    ((r_level >= BURST_LVL) || (r_flush_pend && !w_empty));
    assign w_beat = w_go || ((r_state == S_WDATA) && !app_wdf_afull);
    // An empty FIFO during a beat means this is a flush pad beat.
    assign w_pop  = w_beat && !w_empty;

    assign app_af_cmd = 3'b000;
    assign busy       = (r_state != S_IDLE) || r_flush_pend;
    assign fifo_level = r_level;

    // FIFO storage (data only, never reset)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Burst / command FSM with registered MIG outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_beat_cnt        <= '0;
            r_addr_cnt        <= BASE_ADDR;
            r_flush_pend      <= 1'b0;
            overflow          <= 1'b0;
            burst_cnt         <= '0;
            app_wdf_data      <= '0;
            app_wdf_mask_data <= '0;
            app_wdf_wren      <= 1'b0;
            app_af_addr       <= '0;
            app_af_wren       <= 1'b0;
        end else begin
            app_wdf_wren <= 1'b0;
            app_af_wren  <= 1'b0;

            if (flush) begin
                r_flush_pend <= 1'b1;
            end else if ((r_state == S_IDLE) && w_empty) begin
                r_flush_pend <= 1'b0;
            end

            if (din_vd && w_full) begin
                overflow <= 1'b1;
            end

            if (w_beat) begin
                app_wdf_wren      <= 1'b1;
                app_wdf_data      <= w_empty ? '0 : r_mem[r_rd_ptr];
                app_wdf_mask_data <= w_empty ? '1 : '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start_ld) begin
                        r_addr_cnt <= start_addr;
                    end
                    if (w_go) begin
                        r_beat_cnt <= BCW'(1);
                        r_state    <= (BURST_BEATS == 1) ? S_CMD : S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (!app_wdf_afull) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_state <= S_CMD;
                        end
                    end
                end
                S_CMD: begin
                    if (!app_af_afull) begin
                        app_af_wren <= 1'b1;
                        app_af_addr <= r_addr_cnt;
                        r_addr_cnt  <= r_addr_cnt + STEP;
                        burst_cnt   <= burst_cnt + 16'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
